// File: rtl/rvj1_csr_file_pkg.sv
// Shared CSR addresses, reset values, write masks and write-mode encoding for the rvj1 CSR file.
package rvj1_csr_file_pkg;

   localparam logic [11:0] CSR_ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_ADDR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_ADDR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_ADDR_MHARTID   = 12'hF14;
   localparam logic [11:0] CSR_ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_ADDR_MISA      = 12'h301;
   localparam logic [11:0] CSR_ADDR_MIE       = 12'h304;
   localparam logic [11:0] CSR_ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_ADDR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_ADDR_MIP       = 12'h344;
   localparam logic [11:0] CSR_ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_ADDR_MINSTRETH = 12'hB82;

   localparam logic [29:0] TRAP_VEC_BASE_ADDR = 30'h0010_0000;
   localparam logic [1:0]  TRAP_VEC_MODE      = 2'b00;

   localparam logic [31:0] CSR_DEF_VAL_MVENDORID = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MARCHID   = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MIMPID    = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MSTATUS   = 32'h0000_0000;
   // RV32I
   localparam logic [31:0] CSR_DEF_VAL_MISA      = 32'h4000_0100;
   localparam logic [31:0] CSR_DEF_VAL_MIE       = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MSCRATCH  = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MEPC      = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MCAUSE    = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MTVAL     = 32'h0000_0000;
   localparam logic [31:0] CSR_DEF_VAL_MIP       = 32'h0000_0000;

   localparam logic [31:0] CSR_MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] CSR_MIE_WMASK     = 32'h0000_0888;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam int unsigned IRQ_SW_BIT       = 3;
   localparam int unsigned IRQ_TMR_BIT      = 7;
   localparam int unsigned IRQ_EXT_BIT      = 11;

   typedef enum logic [1:0] {
      CsrWmodeNormal    = 2'b00,
      CsrWmodeSetBits   = 2'b01,
      CsrWmodeClearBits = 2'b10
   } csr_wmode_e;

endpackage

// File: rtl/rvj1_csr_counter.sv
// Free-running CNT_WIDTH counter with separately writable low and high XLEN halves.
module rvj1_csr_counter #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned CNT_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 inc_i,
   input  logic                 wr_lo_i,
   input  logic                 wr_hi_i,
   input  logic [XLEN-1:0]      wdata_i,
   output logic [CNT_WIDTH-1:0] value_o
);

   localparam int unsigned HI_W = CNT_WIDTH - XLEN;

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + {{(CNT_WIDTH-1){1'b0}}, inc_i};

   // A high-half write keeps the incremented low half but drops its carry.
   always_comb begin
      cnt_d = cnt_inc;
      if (wr_lo_i) begin
         cnt_d = {cnt_q[CNT_WIDTH-1:XLEN], wdata_i};
      end else if (wr_hi_i) begin
         cnt_d = {wdata_i[HI_W-1:0], cnt_inc[XLEN-1:0]};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/rvj1_csr_file.sv
// Machine-mode CSR file: Zicsr access, trap entry / MRET sequencing, counters and interrupt
// qualification for the rvj1 core.
module rvj1_csr_file
   import rvj1_csr_file_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     CNT_WIDTH   = 64,
   parameter logic [XLEN-1:0] MHARTID_VAL = 32'h0,
   parameter logic [XLEN-1:0] MTVEC_RST   = {TRAP_VEC_BASE_ADDR, TRAP_VEC_MODE}
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   input  logic [1:0]      csr_wmode_i,
   input  logic            csr_we_i,
   input  logic            csr_re_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_val_i,
   input  logic            mret_i,
   input  logic            instret_i,
   input  logic            irq_ext_i,
   input  logic            irq_tmr_i,
   input  logic            irq_sw_i,
   output logic            irq_pending_o,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o
);

   logic [XLEN-1:0]      mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
   logic [XLEN-1:0]      irq_vec, rd_val, wr_val;
   logic [CNT_WIDTH-1:0] mcycle_val, minstret_val;
   logic                 addr_impl, illegal, wr_en;

   always_comb begin
      irq_vec              = '0;
      irq_vec[IRQ_SW_BIT]  = irq_sw_i;
      irq_vec[IRQ_TMR_BIT] = irq_tmr_i;
      irq_vec[IRQ_EXT_BIT] = irq_ext_i;
   end

   always_comb begin
      addr_impl = 1'b1;
      rd_val    = '0;
      case (csr_addr_i)
         CSR_ADDR_MVENDORID: rd_val = CSR_DEF_VAL_MVENDORID;
         CSR_ADDR_MARCHID:   rd_val = CSR_DEF_VAL_MARCHID;
         CSR_ADDR_MIMPID:    rd_val = CSR_DEF_VAL_MIMPID;
         CSR_ADDR_MHARTID:   rd_val = MHARTID_VAL;
         CSR_ADDR_MSTATUS:   rd_val = mstatus_q;
         CSR_ADDR_MISA:      rd_val = CSR_DEF_VAL_MISA;
         CSR_ADDR_MIE:       rd_val = mie_q;
         CSR_ADDR_MTVEC:     rd_val = mtvec_q;
         CSR_ADDR_MSCRATCH:  rd_val = mscratch_q;
         CSR_ADDR_MEPC:      rd_val = mepc_q;
         CSR_ADDR_MCAUSE:    rd_val = mcause_q;
         CSR_ADDR_MTVAL:     rd_val = mtval_q;
         CSR_ADDR_MIP:       rd_val = mip_q;
         CSR_ADDR_MCYCLE:    rd_val = mcycle_val[XLEN-1:0];
         CSR_ADDR_MINSTRET:  rd_val = minstret_val[XLEN-1:0];
         CSR_ADDR_MCYCLEH:   rd_val = XLEN'(mcycle_val[CNT_WIDTH-1:XLEN]);
         CSR_ADDR_MINSTRETH: rd_val = XLEN'(minstret_val[CNT_WIDTH-1:XLEN]);
         default:            addr_impl = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_wmode_i)
         CsrWmodeNormal:    wr_val = csr_wdata_i;
         CsrWmodeSetBits:   wr_val = rd_val | csr_wdata_i;
         CsrWmodeClearBits: wr_val = rd_val & ~csr_wdata_i;
         default:           wr_val = rd_val;
      endcase
   end

   assign illegal = (csr_re_i | csr_we_i) &
                    (~addr_impl |
                     (csr_we_i & (csr_addr_i[11:10] == 2'b11)) |
                     (csr_we_i & (csr_wmode_i == 2'b11)));

   // Trap and MRET take priority and swallow any concurrent CSR write entirely.
   assign wr_en = csr_we_i & ~illegal & ~trap_i & ~mret_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mstatus_q  <= CSR_DEF_VAL_MSTATUS;
         mie_q      <= CSR_DEF_VAL_MIE;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= CSR_DEF_VAL_MSCRATCH;
         mepc_q     <= CSR_DEF_VAL_MEPC;
         mcause_q   <= CSR_DEF_VAL_MCAUSE;
         mtval_q    <= CSR_DEF_VAL_MTVAL;
         mip_q      <= CSR_DEF_VAL_MIP;
      end else begin
         mip_q <= irq_vec;
         if (trap_i) begin
            mepc_q                      <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_q                    <= trap_cause_i;
            mtval_q                     <= trap_val_i;
            mstatus_q[MSTATUS_MPIE_BIT] <= mstatus_q[MSTATUS_MIE_BIT];
            mstatus_q[MSTATUS_MIE_BIT]  <= 1'b0;
         end else if (mret_i) begin
            mstatus_q[MSTATUS_MIE_BIT]  <= mstatus_q[MSTATUS_MPIE_BIT];
            mstatus_q[MSTATUS_MPIE_BIT] <= 1'b1;
         end else if (wr_en) begin
            case (csr_addr_i)
               CSR_ADDR_MSTATUS:  mstatus_q  <= wr_val & CSR_MSTATUS_WMASK;
               CSR_ADDR_MIE:      mie_q      <= wr_val & CSR_MIE_WMASK;
               CSR_ADDR_MTVEC:    mtvec_q    <= {wr_val[XLEN-1:2], 2'b00};
               CSR_ADDR_MSCRATCH: mscratch_q <= wr_val;
               CSR_ADDR_MEPC:     mepc_q     <= {wr_val[XLEN-1:2], 2'b00};
               CSR_ADDR_MCAUSE:   mcause_q   <= wr_val;
               CSR_ADDR_MTVAL:    mtval_q    <= wr_val;
               default: ;
            endcase
         end
      end
   end

   rvj1_csr_counter #(
      .XLEN      (XLEN),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_mcycle (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .inc_i   (1'b1),
      .wr_lo_i (wr_en && (csr_addr_i == CSR_ADDR_MCYCLE)),
      .wr_hi_i (wr_en && (csr_addr_i == CSR_ADDR_MCYCLEH)),
      .wdata_i (wr_val),
      .value_o (mcycle_val)
   );

   rvj1_csr_counter #(
      .XLEN      (XLEN),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_minstret (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .inc_i   (instret_i),
      .wr_lo_i (wr_en && (csr_addr_i == CSR_ADDR_MINSTRET)),
      .wr_hi_i (wr_en && (csr_addr_i == CSR_ADDR_MINSTRETH)),
      .wdata_i (wr_val),
      .value_o (minstret_val)
   );

   assign csr_rdata_o   = csr_re_i ? rd_val : '0;
   assign csr_illegal_o = illegal;
   assign irq_pending_o = mstatus_q[MSTATUS_MIE_BIT] & (|(mie_q & mip_q));
   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;

endmodule

// File: doc/rvj1_csr_file.md
Name: rvj1_csr_file

Overview:
Machine-mode CSR register file and trap-state sequencer for the rvj1 core, parametrised in XLEN and counter width. It serves Zicsr reads and writes (normal, set and clear modes) from the execute stage. It performs atomic trap entry and MRET state updates, maintains mcycle/minstret, and samples interrupt lines into mip. Outputs mtvec/mepc to fetch and a qualified interrupt request to the controller.

Parameters:
XLEN, 32, register width; 32 is the only supported value.
CNT_WIDTH, 64, mcycle/minstret width; must be in the range XLEN+1..2*XLEN.
MHARTID_VAL, 32'h0, read-only mhartid value.
MTVEC_RST, {TRAP_VEC_BASE_ADDR, TRAP_VEC_MODE}, mtvec reset value.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  write operand (register value or zero-extended uimm)
csr_wmode_i  in  2  CSR_WMODE_NORMAL / CSR_WMODE_SET_BITS / CSR_WMODE_CLEAR_BITS
csr_we_i  in  1  write request
csr_re_i  in  1  read request
csr_rdata_o  out  XLEN  old CSR value
csr_illegal_o  out  1  access is illegal
trap_i  in  1  trap entry strobe
trap_cause_i  in  XLEN  mcause value (bit XLEN-1 = interrupt)
trap_pc_i  in  XLEN  mepc value
trap_val_i  in  XLEN  mtval value
mret_i  in  1  MRET strobe
instret_i  in  1  instruction retired this cycle
irq_ext_i / irq_tmr_i / irq_sw_i  in  1 each  level interrupt lines
irq_pending_o  out  1  interrupt should be taken
mtvec_o  out  XLEN  trap vector
mepc_o  out  XLEN  return address

Behaviour:
- Single clock. Reset is asynchronous and active-low. All state returns to the CSR_DEF_VAL_* values; mtvec returns to MTVEC_RST; counters return to 0.
- Reset values of outputs: csr_rdata_o = 0 (no read active), csr_illegal_o = 0, irq_pending_o = 0, mtvec_o = MTVEC_RST, mepc_o = 0.
- Read path: csr_rdata_o is combinational from the current state in the same cycle. When csr_re_i = 0 it outputs 0.
- Write path: the new value takes effect at the next rising edge.
  - NORMAL: new = wdata.
  - SET: new = old | wdata.
  - CLEAR: new = old & ~wdata.
  - Mode 2'b11 is treated as illegal.
- Implemented CSRs:
  - Read-only: mvendorid, marchid, mimpid, mhartid.
  - Read/write: mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip.
  - Counters: mcycle (B00), minstret (B02), mcycleh (B80), minstreth (B82).
- WARL rules:
  - misa: writes ignored.
  - mstatus: only bits MIE(3) and MPIE(7) are writable; all other bits read 0.
  - mie: only bits 3, 7, 11 are writable.
  - mip: software writes are ignored; bits 3, 7, 11 reflect the sampled lines.
  - mtvec[1:0]: forced to 00.
  - mepc[1:0]: forced to 00.
- csr_illegal_o (combinational) is asserted when any of these holds with (re|we) = 1:
  - unimplemented address;
  - we = 1 while addr[11:10] = 2'b11;
  - wmode = 2'b11 with we = 1.
  An illegal access changes no state.
- Interrupt sampling: mip bits register irq_*_i every cycle, giving one cycle of latency. irq_pending_o = mstatus.MIE & |(mie & mip).
- Trap entry (trap_i = 1), applied at the edge:
  - mepc <= trap_pc_i & ~3;
  - mcause <= trap_cause_i;
  - mtval <= trap_val_i;
  - MPIE <= MIE;
  - MIE <= 0.
- MRET (mret_i = 1): MIE <= MPIE; MPIE <= 1.
- Priority: trap_i > mret_i > CSR write. A lower-priority request in the same cycle is discarded with no partial update.
- mcycle increments every cycle. minstret increments when instret_i = 1. Both wrap modulo 2^CNT_WIDTH.
- Counter halves:
  - A low-half write replaces bits [XLEN-1:0] and suppresses that cycle's increment.
  - A high-half write replaces bits [CNT_WIDTH-1:XLEN]; the low half still increments but carry into the high half is suppressed that cycle.
  - Reads of the high half return zero-extended upper bits.
- The counter is a single CNT_WIDTH adder; carry from the low half into the high half happens in the same cycle.

Decomposition:
- Shared package additions:
  - CSR_ADDR_MCYCLE / MINSTRET / MCYCLEH / MINSTRETH;
  - CSR_MSTATUS_WMASK, CSR_MIE_WMASK;
  - a csr_wmode_e enum replacing the CSR_WMODE_* parameters.
- Sub-module rvj1_csr_counter: parametrised CNT_WIDTH counter with inc_i, low/high write ports and value_o. Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then read at 0x305 -> rdata = 32'h0040_0000, illegal = 0. Read at 0x301 -> 32'h4000_0100.
- Write mscratch 0xA5A5_0000 (NORMAL), then SET 0x0000_00FF, then CLEAR 0xA500_0000 -> reads return 0xA5A5_0000, 0xA5A5_00FF, 0x00A5_00FF.
- With MIE = 1 and mie = 0x800, assert irq_ext_i -> irq_pending_o = 1 one cycle later. Then trap_i with cause 0x8000_000B and pc 0x8000_0102 -> mepc = 0x8000_0100, MIE = 0, MPIE = 1, irq_pending_o = 0. Then mret_i -> MIE = 1.
- Write to 0xF14, and a read at 0x7C0 -> csr_illegal_o = 1 and the state is unchanged.
- Write mcycle low half = 0xFFFF_FFFE with high half = 0 -> two cycles later mcycleh reads 1 and mcycle reads 0. trap_i with a concurrent mscratch write -> mscratch unchanged.
- Reset asserted mid-trap-update (rstn_i low asynchronously) -> all registers are at their reset values before the next edge.
